// File: rtl/vecunit_fp_pkg.sv
// Shared FP32 vector-unit types: rounding-mode encoding and binary32 boundary constants.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package vecunit_fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } rnd_mode_e;

    localparam logic [EXP_W-1:0] EXP_MAX        = 8'hFF;
    localparam logic [EXP_W-1:0] EXP_MAX_FINITE = 8'hFE;
    localparam logic [MAN_W-1:0] MAN_ONES       = 23'h7FFFFF;

    // Unsigned magnitudes (exponent+mantissa); the sign is concatenated by the user.
    localparam logic [EXP_W+MAN_W-1:0] FP32_INF  = {EXP_MAX, {MAN_W{1'b0}}};
    localparam logic [EXP_W+MAN_W-1:0] FP32_MAXF = {EXP_MAX_FINITE, MAN_ONES};

    // Reserved encodings 5..7 behave as round-to-nearest-even.
    function automatic rnd_mode_e norm_mode(input logic [2:0] mode);
        rnd_mode_e m;
        if (mode > 3'd4) begin
            m = RNE;
        end else begin
            m = rnd_mode_e'(mode);
        end
        return m;
    endfunction

endpackage

// File: rtl/fp_round_inc.sv
// Decides whether the truncated mantissa must be bumped by one ulp for the given rounding mode.
// Latency: purely combinational.
// Backpressure: none (no handshake; the caller registers the result).
module fp_round_inc
    import vecunit_fp_pkg::*;
(
    input  logic      i_guard,
    input  logic      i_sticky,
    input  logic      i_lsb,
    input  logic      i_sign,
    input  rnd_mode_e i_mode,
    output logic      o_inc
);

    logic w_inexact;

    assign w_inexact = i_guard | i_sticky;

    // Round-up decision per mode; directed modes only bump when rounding away from zero.
    always_comb begin
        o_inc = 1'b0;
        case (i_mode)
            RNE:     o_inc = i_guard & (i_sticky | i_lsb);
            RTZ:     o_inc = 1'b0;
            RDN:     o_inc = w_inexact & i_sign;
            RUP:     o_inc = w_inexact & ~i_sign;
            RMM:     o_inc = i_guard;
            default: o_inc = i_guard & (i_sticky | i_lsb);
        endcase
    end

endmodule

// File: rtl/fp_add_rounder.sv
// Final FP32 adder stage: applies rounding, mantissa carry and overflow saturation, keeps sticky fflags.
// Latency: 2 cycles in_valid->out_valid, 1 result per cycle.
// Backpressure: in_ready is combinational from out_ready through both stage enables (no skid buffer).
module fp_add_rounder
    import vecunit_fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   pre_result,
    input  logic [1:0]             pre_guard,
    input  logic                   pre_inf,
    input  logic                   res_sign,
    input  logic [2:0]             rnd_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   fp_out,
    output logic                   flag_of,
    output logic                   flag_nx,
    input  logic                   fflags_clr,
    output logic [1:0]             fflags_acc
);

    localparam logic [EXP_W:0] EXP9_SAT = {1'b0, {EXP_W{1'b1}}};

    // Handshake enables
    logic                 w_s1_en;
    logic                 w_s2_en;
    logic                 w_out_hs;

    // Stage 1 state
    logic                 r_s1_vld;
    logic                 r_s1_sign;
    logic                 r_s1_ovf;
    logic                 r_s1_inc;
    logic                 r_s1_inx;
    logic [EXP_W-1:0]     r_s1_exp;
    logic [MAN_W-1:0]     r_s1_mant;
    rnd_mode_e            r_s1_mode;

    // Stage 2 (output) state
    logic                 r_s2_vld;
    logic [EXP_W+MAN_W:0] r_fp_out;
    logic                 r_flag_of;
    logic                 r_flag_nx;
    logic [1:0]           r_acc;

    // Rounding datapath
    rnd_mode_e            w_mode;
    logic                 w_inc;
    logic [MAN_W:0]       w_sum;
    logic [EXP_W:0]       w_exp9;
    logic [MAN_W-1:0]     w_mant;
    logic                 w_ovf;
    logic                 w_to_inf;
    logic [EXP_W+MAN_W:0] w_res;

    assign w_s2_en  = ~r_s2_vld | out_ready;
    assign w_s1_en  = ~r_s1_vld | w_s2_en;
    assign w_out_hs = r_s2_vld & out_ready;

    assign in_ready   = w_s1_en;
    assign out_valid  = r_s2_vld;
    assign fp_out     = r_fp_out;
    assign flag_of    = r_flag_of;
    assign flag_nx    = r_flag_nx;
    assign fflags_acc = r_acc;

    assign w_mode = norm_mode(rnd_mode);

    fp_round_inc u_round_inc (
        .i_guard  (pre_guard[1]),
        .i_sticky (pre_guard[0]),
        .i_lsb    (pre_result[0]),
        .i_sign   (res_sign),
        .i_mode   (w_mode),
        .o_inc    (w_inc)
    );

    // Stage 1: capture the unrounded word and the round-up decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_sign <= 1'b0;
            r_s1_ovf  <= 1'b0;
            r_s1_inc  <= 1'b0;
            r_s1_inx  <= 1'b0;
            r_s1_exp  <= '0;
            r_s1_mant <= '0;
            r_s1_mode <= RNE;
        end else if (w_s1_en) begin
            r_s1_vld  <= in_valid;
            r_s1_sign <= res_sign;
            // pre_inf mirrors the packed overflow bit; either one marks overflow.
            r_s1_ovf  <= pre_inf | pre_result[EXP_W+MAN_W];
            r_s1_inc  <= w_inc;
            r_s1_inx  <= pre_guard[1] | pre_guard[0];
            r_s1_exp  <= pre_result[EXP_W+MAN_W-1:MAN_W];
            r_s1_mant <= pre_result[MAN_W-1:0];
            r_s1_mode <= w_mode;
        end
    end

    // Increment with carry into the exponent; the 9-bit exponent exposes a rounding overflow.
    always_comb begin
        w_sum  = {1'b0, r_s1_mant} + {{MAN_W{1'b0}}, r_s1_inc};
        w_exp9 = {1'b0, r_s1_exp} + {{EXP_W{1'b0}}, w_sum[MAN_W]};
        w_mant = w_sum[MAN_W] ? '0 : w_sum[MAN_W-1:0];
        w_ovf  = r_s1_ovf | (w_exp9 >= EXP9_SAT);
    end

    // Overflow saturates to infinity only when the mode rounds away from zero for this sign.
    always_comb begin
        w_to_inf = 1'b0;
        case (r_s1_mode)
            RNE, RMM: w_to_inf = 1'b1;
            RUP:      w_to_inf = ~r_s1_sign;
            RDN:      w_to_inf = r_s1_sign;
            default:  w_to_inf = 1'b0;
        endcase
    end

    // Final result selection: normal, infinity or largest finite magnitude.
    always_comb begin
        if (w_ovf) begin
            w_res = w_to_inf ? {r_s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                             : {r_s1_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        end else begin
            w_res = {r_s1_sign, w_exp9[EXP_W-1:0], w_mant};
        end
    end

    // Stage 2: registered result and per-result flags, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_vld  <= 1'b0;
            r_fp_out  <= '0;
            r_flag_of <= 1'b0;
            r_flag_nx <= 1'b0;
        end else if (w_s2_en) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_fp_out  <= w_res;
                r_flag_of <= w_ovf;
                r_flag_nx <= r_s1_inx | w_ovf;
            end
        end
    end

    // Sticky flags: a clear coinciding with a handshake keeps only that result's flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= 2'b00;
        end else if (fflags_clr) begin
            r_acc <= w_out_hs ? {r_flag_of, r_flag_nx} : 2'b00;
        end else if (w_out_hs) begin
            r_acc <= r_acc | {r_flag_of, r_flag_nx};
        end
    end

endmodule

// File: tb/tb_fp_add_rounder.sv
// Bench for fp_add_rounder: directed vectors with literal expectations plus a scoreboard model.
// Latency: inputs driven 2 units after the rising edge, outputs sampled on the falling edge.
// Backpressure: out_ready is driven per cycle by the directed sequences.
module tb_fp_add_rounder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pre_result;
    logic [1:0]  pre_guard;
    logic        pre_inf;
    logic        res_sign;
    logic [2:0]  rnd_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] fp_out;
    logic        flag_of;
    logic        flag_nx;
    logic        fflags_clr;
    logic [1:0]  fflags_acc;

    always #5 clk = ~clk;

    fp_add_rounder dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pre_result (pre_result),
        .pre_guard  (pre_guard),
        .pre_inf    (pre_inf),
        .res_sign   (res_sign),
        .rnd_mode   (rnd_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fp_out     (fp_out),
        .flag_of    (flag_of),
        .flag_nx    (flag_nx),
        .fflags_clr (fflags_clr),
        .fflags_acc (fflags_acc)
    );

    typedef struct packed {
        logic [31:0] fp;
        logic        of;
        logic        nx;
    } res_t;

    res_t       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         mon_on = 1'b0;
    logic [1:0] exp_acc = 2'b00;
    bit         prev_stall = 1'b0;
    res_t       held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference: treat {exp,mant} as one integer magnitude, add an ulp when rounding away from zero.
    function automatic res_t model(input logic [31:0] pre, input logic g, input logic s,
                                   input logic sign, input logic [2:0] mode);
        res_t        r;
        int          m;
        bit          up;
        bit          inx;
        bit          ovf;
        bit          to_inf;
        logic [31:0] mag;
        m   = (mode > 3'd4) ? 0 : int'(mode);
        inx = g || s;
        case (m)
            0:       up = g && (s || pre[0]);
            1:       up = 1'b0;
            2:       up = inx && sign;
            3:       up = inx && !sign;
            default: up = g;
        endcase
        mag    = {1'b0, pre[30:0]} + (up ? 32'd1 : 32'd0);
        ovf    = pre[31] || (mag >= 32'h7F80_0000);
        to_inf = (m == 0) || (m == 4) || (m == 3 && !sign) || (m == 2 && sign);
        if (ovf) begin
            r.fp = to_inf ? {sign, 31'h7F80_0000} : {sign, 31'h7F7F_FFFF};
        end else begin
            r.fp = {sign, mag[30:0]};
        end
        r.of = ovf;
        r.nx = inx || ovf;
        return r;
    endfunction

    // Scoreboard and per-cycle checks, sampled on the falling edge.
    always @(negedge clk) begin
        res_t e;
        if (mon_on) begin
            chk("acc_track", {30'd0, fflags_acc}, {30'd0, exp_acc});
            if (prev_stall) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_fp", fp_out, held.fp);
                chk("stall_flags", {30'd0, flag_of, flag_nx}, {30'd0, held.of, held.nx});
            end
            if (!rst && exp_q.size() == 0) begin
                chk("spurious_valid", {31'd0, out_valid}, 32'd0);
            end
            if (!rst && out_valid && out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_fp", fp_out, e.fp);
                chk("out_of", {31'd0, flag_of}, {31'd0, e.of});
                chk("out_nx", {31'd0, flag_nx}, {31'd0, e.nx});
                if (fflags_clr) exp_acc = {e.of, e.nx};
                else            exp_acc = exp_acc | {e.of, e.nx};
            end else if (!rst && fflags_clr) begin
                exp_acc = 2'b00;
            end
            if (!rst && in_valid && in_ready) begin
                exp_q.push_back(model(pre_result, pre_guard[1], pre_guard[0], res_sign, rnd_mode));
            end
            prev_stall = !rst && out_valid && !out_ready;
            held       = {fp_out, flag_of, flag_nx};
            if (rst) begin
                exp_q.delete();
                exp_acc    = 2'b00;
                prev_stall = 1'b0;
            end
        end
    end

    // Present one word and hold it until accepted (called 2 units after a rising edge).
    task automatic send(input logic [31:0] pre, input logic g, input logic s,
                        input logic sign, input logic [2:0] mode);
        bit ok;
        ok         = 1'b0;
        pre_result = pre;
        pre_inf    = pre[31];
        pre_guard  = {g, s};
        res_sign   = sign;
        rnd_mode   = mode;
        in_valid   = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #2;
        end
        chk("send_accept", {31'd0, ok}, 32'd1);
        in_valid = 1'b0;
    endtask

    // Pin the model to a hand-computed result, then stream the word through the DUT.
    task automatic vec(input string name, input logic [31:0] pre, input logic g, input logic s,
                       input logic sign, input logic [2:0] mode,
                       input logic [31:0] efp, input logic eof, input logic enx);
        res_t m;
        m = model(pre, g, s, sign, mode);
        chk({name, "_fp"}, m.fp, efp);
        chk({name, "_flags"}, {30'd0, m.of, m.nx}, {30'd0, eof, enx});
        send(pre, g, s, sign, mode);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    // Raise fflags_clr in exactly the cycle the pending result is handed off.
    task automatic clr_on_out(input string name, input logic [1:0] eacc);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk);
            #2;
            if (out_valid) begin
                fflags_clr = 1'b1;
                @(posedge clk);
                #2;
                fflags_clr = 1'b0;
                done = 1'b1;
            end
        end
        chk({name, "_seen"}, {31'd0, done}, 32'd1);
        chk(name, {30'd0, fflags_acc}, {30'd0, eacc});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        pre_result = '0;
        pre_guard  = '0;
        pre_inf    = 1'b0;
        res_sign   = 1'b0;
        rnd_mode   = 3'd0;
        out_ready  = 1'b1;
        fflags_clr = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_fp_out", fp_out, 32'd0);
        chk("rst_flags", {30'd0, flag_of, flag_nx}, 32'd0);
        chk("rst_acc", {30'd0, fflags_acc}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        exp_acc = 2'b00;
        mon_on  = 1'b1;
        @(posedge clk);
        #2;

        // Rounding and overflow vectors, streamed back to back.
        vec("rne_tie_even",     32'h3F80_0000, 1, 0, 0, 3'd0, 32'h3F80_0000, 0, 1);
        vec("rne_tie_odd",      32'h3F80_0001, 1, 0, 0, 3'd0, 32'h3F80_0002, 0, 1);
        vec("rne_above_half",   32'h3F80_0000, 1, 1, 0, 3'd0, 32'h3F80_0001, 0, 1);
        vec("rne_below_half",   32'h3F80_0001, 0, 1, 0, 3'd0, 32'h3F80_0001, 0, 1);
        vec("carry_out",        32'h3FFF_FFFF, 1, 1, 0, 3'd0, 32'h4000_0000, 0, 1);
        vec("ovf_rne",          32'h7F7F_FFFF, 1, 1, 0, 3'd0, 32'h7F80_0000, 1, 1);
        vec("rtz_near_max",     32'h7F7F_FFFF, 1, 1, 0, 3'd1, 32'h7F7F_FFFF, 0, 1);
        vec("rup_neg_near_max", 32'h7F7F_FFFF, 1, 1, 1, 3'd3, 32'hFF7F_FFFF, 0, 1);
        vec("ovf_rdn_neg",      32'h7F7F_FFFF, 0, 1, 1, 3'd2, 32'hFF80_0000, 1, 1);
        vec("ovf_rmm",          32'h7F7F_FFFF, 1, 0, 0, 3'd4, 32'h7F80_0000, 1, 1);
        vec("ovf_in_rtz",       32'h8000_0000, 0, 0, 0, 3'd1, 32'h7F7F_FFFF, 1, 1);
        vec("ovf_in_rup_neg",   32'h8000_0000, 0, 0, 1, 3'd3, 32'hFF7F_FFFF, 1, 1);
        vec("ovf_in_rup_pos",   32'h8000_0000, 0, 0, 0, 3'd3, 32'h7F80_0000, 1, 1);
        for (int m = 0; m < 8; m++) begin
            vec("exact", 32'h4040_0000, 0, 0, 0, 3'(m), 32'h4040_0000, 0, 0);
        end
        vec("rdn_neg_sticky",   32'h4040_0000, 0, 1, 1, 3'd2, 32'hC040_0001, 0, 1);
        vec("rup_neg_sticky",   32'h4040_0000, 0, 1, 1, 3'd3, 32'hC040_0000, 0, 1);
        vec("rup_pos_sticky",   32'h4040_0000, 0, 1, 0, 3'd3, 32'h4040_0001, 0, 1);
        vec("rdn_pos_sticky",   32'h4040_0000, 0, 1, 0, 3'd2, 32'h4040_0000, 0, 1);
        vec("rmm_tie",          32'h3F80_0000, 1, 0, 0, 3'd4, 32'h3F80_0001, 0, 1);
        vec("mode6_as_rne",     32'h3F80_0001, 1, 0, 0, 3'd6, 32'h3F80_0002, 0, 1);
        vec("denorm_rup",       32'h0000_0005, 1, 1, 0, 3'd3, 32'h0000_0006, 0, 1);
        drain();
        chk("acc_after_vecs", {30'd0, fflags_acc}, 32'd3);

        // Backpressure: four words, downstream stalls for cycles 3..5.
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    vec("bp", 32'h4100_0000 + i, 0, 1, 0, 3'd1, 32'h4100_0000 + i, 0, 1);
                end
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    out_ready = !(c >= 3 && c <= 5);
                    if (c == 4) begin
                        #3;
                        chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
                        chk("bp_out_held", {31'd0, out_valid}, 32'd1);
                    end
                    @(posedge clk);
                    #2;
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Flags: clear alone, accumulate inexact, clear alongside handshakes.
        fflags_clr = 1'b1;
        @(posedge clk);
        #2;
        fflags_clr = 1'b0;
        chk("clr_alone", {30'd0, fflags_acc}, 32'd0);
        vec("nx_a", 32'h3F80_0000, 1, 0, 0, 3'd0, 32'h3F80_0000, 0, 1);
        vec("nx_b", 32'h3F80_0001, 0, 1, 0, 3'd1, 32'h3F80_0001, 0, 1);
        vec("nx_c", 32'h3F80_0002, 1, 1, 0, 3'd0, 32'h3F80_0003, 0, 1);
        drain();
        chk("acc_three_nx", {30'd0, fflags_acc}, 32'd1);
        vec("clr_ovf", 32'h7F7F_FFFF, 1, 1, 0, 3'd0, 32'h7F80_0000, 1, 1);
        clr_on_out("clr_with_ovf", 2'b11);
        vec("clr_exact", 32'h4040_0000, 0, 0, 0, 3'd0, 32'h4040_0000, 0, 0);
        clr_on_out("clr_with_exact", 2'b00);

        // Reset with two results in flight.
        vec("pre_rst", 32'h3F80_0000, 1, 1, 0, 3'd0, 32'h3F80_0001, 0, 1);
        drain();
        chk("acc_before_rst", {30'd0, fflags_acc}, 32'd1);
        send(32'h3F80_0010, 1, 1, 0, 3'd0);
        send(32'h3F80_0020, 1, 1, 0, 3'd0);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_flush_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_flush_acc", {30'd0, fflags_acc}, 32'd0);
        chk("rst_flush_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #2;
        vec("post_rst", 32'h3FFF_FFFF, 1, 0, 0, 3'd4, 32'h4000_0000, 0, 1);
        drain();
        repeat (3) @(posedge clk);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
